// File: rtl/frame_burst_writer_pkg.sv
// Shared types and defaults for the burst frame writer: FSM state encoding and buffer index width.
package frame_burst_writer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_FILL,
    ST_BURST,
    ST_DONE
  } state_t;

  localparam int DEF_BURST_LEN = 64;
  localparam int DEF_NUM_BUF   = 3;
  localparam int BUF_IDX_W     = 2;

endpackage

// File: rtl/frame_burst_writer_if.sv
// Frame request, pixel stream, SDRAM App_wr_* bus and buffer status of the burst frame writer.
interface frame_burst_writer_if
  import frame_burst_writer_pkg::*;
#(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 21,
  parameter int LEN_BITS  = 24
) ();

  logic                   write_req;
  logic                   write_req_ack;
  logic [LEN_BITS-1:0]    write_len;
  logic                   s_valid;
  logic                   s_ready;
  logic [DATA_BITS-1:0]   s_data;
  logic                   Sdr_init_done;
  logic                   Sdr_busy;
  logic                   App_wr_en;
  logic [ADDR_BITS-1:0]   App_wr_addr;
  logic [DATA_BITS-1:0]   App_wr_din;
  logic [DATA_BITS/8-1:0] App_wr_dm;
  logic                   write_finish;
  logic [BUF_IDX_W-1:0]   cur_buf;
  logic [BUF_IDX_W-1:0]   last_buf;
  logic                   frame_valid;

  modport master (
    input  write_req, write_len, s_valid, s_data, Sdr_init_done, Sdr_busy,
    output write_req_ack, s_ready, App_wr_en, App_wr_addr, App_wr_din, App_wr_dm,
           write_finish, cur_buf, last_buf, frame_valid
  );

  modport slave (
    output write_req, write_len, s_valid, s_data, Sdr_init_done, Sdr_busy,
    input  write_req_ack, s_ready, App_wr_en, App_wr_addr, App_wr_din, App_wr_dm,
           write_finish, cur_buf, last_buf, frame_valid
  );

endinterface

// File: rtl/frame_burst_writer_sync_fifo.sv
// First-word-fall-through FIFO with occupancy count; the head word is valid whenever not empty.
module frame_burst_writer_sync_fifo #(
  parameter int DATA_BITS = 32,
  parameter int DEPTH     = 128
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_BITS-1:0]       din,
  input  logic                       pop,
  output logic [DATA_BITS-1:0]       dout,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW:0]          cnt;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (cnt == FULL_CNT);
  assign do_push = push && !full;
  assign do_pop  = pop && (cnt != '0);
  assign dout    = mem[rd_ptr];
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW + 1)'(1);
        2'b01:   cnt <= cnt - (AW + 1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset: contents are only meaningful behind the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/frame_burst_writer.sv
// Buffers a pixel stream and writes it to SDRAM in bursts, rotating over NUM_BUF frame buffers.
module frame_burst_writer
  import frame_burst_writer_pkg::*;
#(
  parameter int                   DATA_BITS  = 32,
  parameter int                   ADDR_BITS  = 21,
  parameter int                   LEN_BITS   = 24,
  parameter int                   BURST_LEN  = DEF_BURST_LEN,
  parameter int                   FIFO_DEPTH = 128,
  parameter int                   NUM_BUF    = DEF_NUM_BUF,
  parameter logic [ADDR_BITS-1:0] BASE_ADDR  = '0,
  parameter logic [ADDR_BITS-1:0] BUF_STRIDE = ADDR_BITS'(32'h80000)
) (
  input logic                   clk,
  input logic                   rst,
  frame_burst_writer_if.master  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int BL_W  = $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

  state_t               state;
  logic [LEN_BITS-1:0]  rem_in;
  logic [LEN_BITS-1:0]  rem_out;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [BL_W-1:0]      burst_left;
  logic [BUF_IDX_W-1:0] cur_buf;
  logic [BUF_IDX_W-1:0] last_buf;
  logic                 frame_valid;

  logic                 s_ready;
  logic                 push;
  logic                 wr_en;
  logic                 fifo_full;
  logic [CNT_W-1:0]     fifo_count;
  logic [DATA_BITS-1:0] fifo_head;
  logic                 burst_ready;

  function automatic logic [BL_W-1:0] burst_words(input logic [LEN_BITS-1:0] rem);
    if (rem >= LEN_BITS'(BURST_LEN)) return BL_W'(BURST_LEN);
    return BL_W'(rem);
  endfunction

  function automatic logic [BUF_IDX_W-1:0] next_buf(input logic [BUF_IDX_W-1:0] b);
    return (b == BUF_IDX_W'(NUM_BUF - 1)) ? '0 : b + BUF_IDX_W'(1);
  endfunction

  function automatic logic [ADDR_BITS-1:0] buf_base(input logic [BUF_IDX_W-1:0] b);
    return BASE_ADDR + BUF_STRIDE * ADDR_BITS'(b);
  endfunction

  assign s_ready = ((state == ST_FILL) || (state == ST_BURST)) && !fifo_full && (rem_in != '0);
  assign push    = bus.s_valid && s_ready;
  // Pop and strobe share the cycle so the FWFT head lands on App_wr_din with its enable.
  assign wr_en   = (state == ST_BURST) && !bus.Sdr_busy;
  // Occupancy never exceeds rem_out, so the equality term catches the final short burst.
  assign burst_ready = !bus.Sdr_busy &&
                       ((fifo_count >= BURST_CNT) || (LEN_BITS'(fifo_count) == rem_out));

  frame_burst_writer_sync_fifo #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (bus.s_data),
    .pop   (wr_en),
    .dout  (fifo_head),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rem_in      <= '0;
      rem_out     <= '0;
      wr_addr     <= '0;
      burst_left  <= '0;
      cur_buf     <= '0;
      last_buf    <= '0;
      frame_valid <= 1'b0;
    end else begin
      if (push) rem_in <= rem_in - LEN_BITS'(1);
      case (state)
        ST_IDLE: begin
          if (bus.write_req && bus.Sdr_init_done && (bus.write_len != '0)) state <= ST_ACK;
        end
        ST_ACK: begin
          rem_in  <= bus.write_len;
          rem_out <= bus.write_len;
          wr_addr <= buf_base(cur_buf);
          state   <= ST_FILL;
        end
        ST_FILL: begin
          if (burst_ready) begin
            burst_left <= burst_words(rem_out);
            state      <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (!bus.Sdr_busy) begin
            wr_addr    <= wr_addr + ADDR_BITS'(1);
            rem_out    <= rem_out - LEN_BITS'(1);
            burst_left <= burst_left - BL_W'(1);
            if (burst_left == BL_W'(1)) state <= (rem_out == LEN_BITS'(1)) ? ST_DONE : ST_FILL;
          end
        end
        ST_DONE: begin
          last_buf    <= cur_buf;
          frame_valid <= 1'b1;
          cur_buf     <= next_buf(cur_buf);
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.write_req_ack = (state == ST_ACK);
  assign bus.write_finish  = (state == ST_DONE);
  assign bus.s_ready       = s_ready;
  assign bus.App_wr_en     = wr_en;
  assign bus.App_wr_addr   = wr_addr;
  assign bus.App_wr_din    = wr_en ? fifo_head : '0;
  assign bus.App_wr_dm     = '0;
  assign bus.cur_buf       = cur_buf;
  assign bus.last_buf      = last_buf;
  assign bus.frame_valid   = frame_valid;

endmodule

// File: tb/tb_frame_burst_writer.sv
// Randomized frame traffic for frame_burst_writer, scored against a per-frame address/data/buffer model.
`timescale 1ns/1ps
module tb_frame_burst_writer;
  import frame_burst_writer_pkg::*;

  localparam int DATA_BITS  = 32;
  localparam int ADDR_BITS  = 21;
  localparam int LEN_BITS   = 24;
  localparam int BURST_LEN  = 64;
  localparam int FIFO_DEPTH = 128;
  localparam int NUM_BUF    = 3;
  localparam int T_BASE     = 0;
  localparam int T_STRIDE   = 'h80000;
  localparam int ADDR_MASK  = (1 << ADDR_BITS) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_burst_writer_if #(.DATA_BITS(DATA_BITS), .ADDR_BITS(ADDR_BITS), .LEN_BITS(LEN_BITS)) bus_if ();

  frame_burst_writer #(
    .DATA_BITS  (DATA_BITS),
    .ADDR_BITS  (ADDR_BITS),
    .LEN_BITS   (LEN_BITS),
    .BURST_LEN  (BURST_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .NUM_BUF    (NUM_BUF),
    .BASE_ADDR  (ADDR_BITS'(T_BASE)),
    .BUF_STRIDE (ADDR_BITS'(T_STRIDE))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: which buffer the next frame goes to and what has completed.
  int model_buf   = 0;
  int model_last  = 0;
  bit model_valid = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ack"},      bus_if.write_req_ack, 0);
    check({tag, "_s_ready"},  bus_if.s_ready, 0);
    check({tag, "_wr_en"},    bus_if.App_wr_en, 0);
    check({tag, "_wr_addr"},  bus_if.App_wr_addr, 0);
    check({tag, "_wr_din"},   bus_if.App_wr_din, 0);
    check({tag, "_wr_dm"},    bus_if.App_wr_dm, 0);
    check({tag, "_finish"},   bus_if.write_finish, 0);
    check({tag, "_cur_buf"},  bus_if.cur_buf, 0);
    check({tag, "_last_buf"}, bus_if.last_buf, 0);
    check({tag, "_fvalid"},   bus_if.frame_valid, 0);
  endtask

  // busy_mode: 0 none, 1 random, 2 five cycles once ten words are written. rst_at>0 aborts the frame.
  task automatic run_frame(input int len, input bit cont, input int busy_mode, input int rst_at);
    logic [31:0] data[$];
    int  runs[$];
    int  base, accepted, writes, run, busy_left, busy_low, rem, idx;
    bit  done, aborted, busy_fired, got_ack, hs;
    accepted = 0; writes = 0; run = 0; busy_left = 0; busy_low = 0;
    done = 0; aborted = 0; busy_fired = 0; got_ack = 0;
    for (int k = 0; k < len; k++) data.push_back($urandom);
    base = (T_BASE + model_buf * T_STRIDE) & ADDR_MASK;

    @(posedge clk); #1;
    bus_if.write_len = LEN_BITS'(len);
    bus_if.write_req = 1'b1;
    for (int t = 0; t < 50 && !got_ack; t++) begin
      @(negedge clk);
      got_ack = bus_if.write_req_ack;
    end
    check("frame_ack", got_ack, 1);
    if (!got_ack) begin
      bus_if.write_req = 1'b0;
      return;
    end
    check("cur_buf_at_ack", bus_if.cur_buf, model_buf);
    check("fvalid_at_ack", bus_if.frame_valid, model_valid);
    @(posedge clk); #1;
    bus_if.write_req = 1'b0;

    fork
      begin
        while (accepted < len && !done && !aborted) begin
          bus_if.s_valid = cont || ($urandom_range(0, 3) != 0);
          bus_if.s_data  = data[accepted];
          @(negedge clk);
          hs = bus_if.s_valid && bus_if.s_ready;
          @(posedge clk); #1;
          if (hs) accepted++;
        end
        bus_if.s_valid = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < len * 16 + 400 && !done; cyc++) begin
          @(negedge clk);
          if (bus_if.Sdr_busy) begin
            check("busy_gate", bus_if.App_wr_en, 0);
            if (!bus_if.App_wr_en) busy_low++;
          end
          if (bus_if.App_wr_en) begin
            if (writes < len) begin
              check("wr_addr", bus_if.App_wr_addr, (base + writes) & ADDR_MASK);
              check("wr_data", bus_if.App_wr_din, data[writes]);
            end else begin
              check("extra_write", 1, 0);
            end
            writes++;
            run++;
          end else if (run != 0 && !bus_if.Sdr_busy) begin
            runs.push_back(run);
            run = 0;
          end
          if (bus_if.write_finish) done = 1;
          if (rst_at > 0 && writes == rst_at && !done) begin
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            aborted = 1;
            @(negedge clk);
            check_idle_outputs("rst_mid");
            done = 1;
          end else begin
            case (busy_mode)
              1: bus_if.Sdr_busy = ($urandom_range(0, 7) == 0);
              2: begin
                if (!busy_fired && writes >= 10) begin
                  busy_fired = 1;
                  busy_left  = 5;
                end
                bus_if.Sdr_busy = (busy_left > 0);
                if (busy_left > 0) busy_left--;
              end
              default: bus_if.Sdr_busy = 1'b0;
            endcase
            @(posedge clk); #1;
          end
        end
        if (!done) begin
          check("finish_timeout", 0, 1);
          done = 1;
        end
      end
    join
    bus_if.Sdr_busy = 1'b0;

    if (aborted) begin
      model_buf   = 0;
      model_last  = 0;
      model_valid = 0;
      return;
    end

    check("write_count", writes, len);
    if (busy_mode == 2) check("busy_hold_cycles", busy_low, 5);
    if (busy_mode == 0) begin
      rem = len;
      idx = 0;
      while (rem > 0) begin
        int exp_run;
        exp_run = (rem > BURST_LEN) ? BURST_LEN : rem;
        check("burst_len", (idx < runs.size()) ? runs[idx] : 0, exp_run);
        rem -= exp_run;
        idx++;
      end
      check("burst_count", runs.size(), idx);
    end

    model_last  = model_buf;
    model_buf   = (model_buf + 1) % NUM_BUF;
    model_valid = 1;

    @(negedge clk);
    check("last_buf", bus_if.last_buf, model_last);
    check("frame_valid", bus_if.frame_valid, 1);
    check("cur_buf_next", bus_if.cur_buf, model_buf);
    check("single_finish", bus_if.write_finish, 0);
    @(posedge clk); #1;
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = $urandom;
    @(negedge clk);
    check("s_ready_beyond_len", bus_if.s_ready, 0);
    check("no_write_after", bus_if.App_wr_en, 0);
    @(posedge clk); #1;
    bus_if.s_valid = 1'b0;
  endtask

  initial begin
    bit seen;
    bus_if.write_req     = 1'b0;
    bus_if.write_len     = '0;
    bus_if.s_valid       = 1'b0;
    bus_if.s_data        = '0;
    bus_if.Sdr_init_done = 1'b0;
    bus_if.Sdr_busy      = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");

    // Zero-length request must never be accepted.
    @(posedge clk); #1;
    bus_if.Sdr_init_done = 1'b1;
    bus_if.write_len     = '0;
    bus_if.write_req     = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.write_req_ack) seen = 1;
    end
    check("ack_len_zero", seen, 0);

    // Request held while SDRAM is still initialising.
    @(posedge clk); #1;
    bus_if.Sdr_init_done = 1'b0;
    bus_if.write_len     = LEN_BITS'(128);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_if.write_req_ack) seen = 1;
    end
    check("ack_before_init", seen, 0);
    @(posedge clk); #1;
    bus_if.Sdr_init_done = 1'b1;

    run_frame(128, 1'b1, 0, 0);
    run_frame(100, 1'b0, 0, 0);
    run_frame(128, 1'b1, 2, 0);
    run_frame(70,  1'b0, 1, 0);
    run_frame(128, 1'b1, 0, 50);
    run_frame(64,  1'b1, 0, 0);
    run_frame(1,   1'b1, 0, 0);
    for (int f = 0; f < 4; f++) begin
      run_frame($urandom_range(1, 200), 1'b0, int'($urandom_range(0, 1)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
